digital_clock_counter: RTL and testbench

Time-keeping core of the digital clock: divides the system clock down to a one-second tick and maintains a 24-hour hours/minutes/seconds count. It provides a two-button time-set mode. It produces the `hr`/`min`/`sec` binary values that the seven-segment display multiplexer consumes, so it sits directly upstream of the display block on the same clock.

---
 rtl/digital_clock_counter.sv | 124 ++++++++++++
 tb/tb_digital_clock_counter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_clock_counter.sv
// Time-keeping core: divides clk_out down to a one-second tick and keeps a 24-hour
// hr/min/sec count, with a two-button (mode/increment) time-set mode.
module digital_clock_counter #(
  parameter int CLK_DIV = 100000000
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [4:0] hr,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] set_mode,
  output logic       sec_tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_t;

  mode_t         state_reg, state_next;
  logic [PW-1:0] presc_reg;
  logic          mode_prev_reg, inc_prev_reg;
  logic [4:0]    hr_reg;
  logic [5:0]    min_reg, sec_reg;
  logic          mode_press, inc_press, inc_apply;
  logic          sec_wrap, min_wrap, hr_wrap;

  // History registers come out of reset at 1 so a held button is not a press.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      mode_prev_reg <= 1'b1;
      inc_prev_reg  <= 1'b1;
    end else begin
      mode_prev_reg <= mode_btn;
      inc_prev_reg  <= inc_btn;
    end
  end

  assign mode_press = mode_btn & ~mode_prev_reg;
  assign inc_press  = inc_btn & ~inc_prev_reg;
  assign inc_apply  = inc_press & ~mode_press;

  // Mode FSM: state register
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  // Mode FSM: next state
  always_comb begin
    state_next = state_reg;
    if (mode_press) begin
      case (state_reg)
        RUN:     state_next = SET_HR;
        SET_HR:  state_next = SET_MIN;
        default: state_next = RUN;
      endcase
    end
  end

  // Mode FSM: outputs
  always_comb begin
    set_mode = state_reg;
    sec_tick = (state_reg == RUN) && (presc_reg == PRESC_MAX);
  end

  // Prescaler only runs while staying in RUN, so every RUN entry restarts it at 0.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset)
      presc_reg <= '0;
    else if (state_reg != RUN || state_next != RUN || sec_tick)
      presc_reg <= '0;
    else
      presc_reg <= presc_reg + PW'(1);
  end

  assign sec_wrap = (sec_reg == 6'd59);
  assign min_wrap = (min_reg == 6'd59);
  assign hr_wrap  = (hr_reg == 5'd23);

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      hr_reg  <= '0;
      min_reg <= '0;
      sec_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (sec_tick) begin
            sec_reg <= sec_wrap ? 6'd0 : sec_reg + 6'd1;
            if (sec_wrap)
              min_reg <= min_wrap ? 6'd0 : min_reg + 6'd1;
            if (sec_wrap && min_wrap)
              hr_reg <= hr_wrap ? 5'd0 : hr_reg + 5'd1;
          end
        end
        SET_HR: begin
          if (inc_apply)
            hr_reg <= hr_wrap ? 5'd0 : hr_reg + 5'd1;
        end
        SET_MIN: begin
          if (inc_apply)
            min_reg <= min_wrap ? 6'd0 : min_reg + 6'd1;
          if (mode_press)
            sec_reg <= 6'd0;
        end
        default: begin
          sec_reg <= sec_reg;
        end
      endcase
    end
  end

  assign hr  = hr_reg;
  assign min = min_reg;
  assign sec = sec_reg;

endmodule

// File: tb/tb_digital_clock_counter.sv
// Self-checking bench for digital_clock_counter: directed scenarios plus random button
// traffic, all compared every cycle against a seconds-of-day reference model.
module tb_digital_clock_counter;

  localparam int CLK_DIV = 4;

  logic       clk_out = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [4:0] d_hr;
  logic [5:0] d_min, d_sec;
  logic [1:0] d_mode;
  logic       d_tick;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  digital_clock_counter #(.CLK_DIV(CLK_DIV)) dut (
    .clk_out (clk_out),
    .reset   (reset),
    .mode_btn(mode_btn),
    .inc_btn (inc_btn),
    .hr      (d_hr),
    .min     (d_min),
    .sec     (d_sec),
    .set_mode(d_mode),
    .sec_tick(d_tick)
  );

  always #5 clk_out = ~clk_out;

  // Reference model: mode 0 RUN / 1 SET_HR / 2 SET_MIN, time kept as h/m/s integers.
  typedef struct {
    int mode;
    int presc;
    int h;
    int m;
    int s;
    int pm;
    int pi;
  } mstate_t;

  mstate_t mdl;

  function automatic mstate_t reset_state();
    mstate_t r;
    r.mode = 0; r.presc = 0; r.h = 0; r.m = 0; r.s = 0; r.pm = 1; r.pi = 1;
    return r;
  endfunction

  function automatic mstate_t step(input mstate_t c, input bit mb, input bit ib);
    mstate_t n;
    bit mp, ip, tick;
    int secs;
    n = c;
    mp = mb && (c.pm == 0);
    ip = ib && (c.pi == 0);
    if (c.mode == 0) begin
      tick = (c.presc == CLK_DIV - 1);
      if (tick) begin
        secs = (c.h * 3600 + c.m * 60 + c.s + 1) % 86400;
        n.h = secs / 3600;
        n.m = (secs / 60) % 60;
        n.s = secs % 60;
        n.presc = 0;
      end else begin
        n.presc = c.presc + 1;
      end
    end else begin
      n.presc = 0;
      if (ip && !mp && c.mode == 1) n.h = (c.h + 1) % 24;
      if (ip && !mp && c.mode == 2) n.m = (c.m + 1) % 60;
    end
    if (mp) begin
      n.presc = 0;
      if (c.mode == 2) begin
        n.mode = 0;
        n.s = 0;
      end else begin
        n.mode = c.mode + 1;
      end
    end
    n.pm = mb;
    n.pi = ib;
    return n;
  endfunction

  always @(posedge clk_out or posedge reset) begin
    if (reset) mdl <= reset_state();
    else       mdl <= step(mdl, mode_btn, inc_btn);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_out) begin
    if (chk_en) begin
      check("model_hr", d_hr, mdl.h);
      check("model_min", d_min, mdl.m);
      check("model_sec", d_sec, mdl.s);
      check("model_mode", d_mode, mdl.mode);
      check("model_tick", d_tick, (mdl.mode == 0 && mdl.presc == CLK_DIV - 1) ? 1 : 0);
    end
  end

  task automatic press_mode();
    mode_btn = 1'b1;
    @(negedge clk_out);
    mode_btn = 1'b0;
    @(negedge clk_out);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      inc_btn = 1'b1;
      @(negedge clk_out);
      inc_btn = 1'b0;
      @(negedge clk_out);
    end
  endtask

  initial begin
    reset = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk_out);
    check("rst_hr", d_hr, 0);
    check("rst_min", d_min, 0);
    check("rst_sec", d_sec, 0);
    check("rst_mode", d_mode, 0);
    check("rst_tick", d_tick, 0);
    reset = 1'b0;

    // Basic run: tick in every 4th cycle, sec visible one cycle later.
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_out);
      if (k % 4 == 3) check("run_tick", d_tick, 1);
      if (k % 4 == 0) check("run_sec", d_sec, k / 4);
    end

    // SET_HR entry, freeze, then hour arithmetic with wrap.
    press_mode();
    check("sethr_mode", d_mode, 1);
    repeat (20) @(negedge clk_out);
    check("freeze_sec", d_sec, 3);
    check("freeze_tick", d_tick, 0);
    press_inc(27);
    check("sethr_hr", d_hr, 3);
    press_mode();
    check("setmin_mode", d_mode, 2);
    press_inc(61);
    check("setmin_min", d_min, 1);
    check("setmin_hr", d_hr, 3);

    // Back to RUN: sec cleared, first tick exactly CLK_DIV cycles after.
    mode_btn = 1'b1;
    @(negedge clk_out);
    mode_btn = 1'b0;
    check("restart_mode", d_mode, 0);
    check("restart_sec", d_sec, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_out);
      check("restart_tick", d_tick, (k == 3 || k == 7) ? 1 : 0);
      if (k == 4) check("restart_sec1", d_sec, 1);
    end

    // Button corner cases.
    press_inc(1);
    check("run_inc_hr", d_hr, 3);
    check("run_inc_min", d_min, 1);
    press_mode();
    inc_btn = 1'b1;
    repeat (10) @(negedge clk_out);
    inc_btn = 1'b0;
    @(negedge clk_out);
    check("held_inc_hr", d_hr, 4);
    mode_btn = 1'b1;
    inc_btn = 1'b1;
    @(negedge clk_out);
    check("both_mode", d_mode, 2);
    check("both_hr", d_hr, 4);
    mode_btn = 1'b0;
    inc_btn = 1'b0;
    @(negedge clk_out);
    press_mode();

    // Full rollover from 23:59:59.
    press_mode();
    press_inc(19);
    check("roll_hr23", d_hr, 23);
    press_mode();
    press_inc(58);
    check("roll_min59", d_min, 59);
    mode_btn = 1'b1;
    @(negedge clk_out);
    mode_btn = 1'b0;
    repeat (59 * CLK_DIV) @(negedge clk_out);
    check("roll_pre_hr", d_hr, 23);
    check("roll_pre_min", d_min, 59);
    check("roll_pre_sec", d_sec, 59);
    repeat (CLK_DIV) @(negedge clk_out);
    check("roll_hr", d_hr, 0);
    check("roll_min", d_min, 0);
    check("roll_sec", d_sec, 0);

    // Reset mid-set with both buttons held.
    press_mode();
    press_mode();
    press_inc(42);
    check("mid_min42", d_min, 42);
    mode_btn = 1'b1;
    inc_btn = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_min", d_min, 0);
    check("async_mode", d_mode, 0);
    check("async_sec", d_sec, 0);
    check("async_tick", d_tick, 0);
    repeat (2) @(negedge clk_out);
    reset = 1'b0;
    repeat (CLK_DIV) @(negedge clk_out);
    check("post_rst_mode", d_mode, 0);
    check("post_rst_sec", d_sec, 1);
    mode_btn = 1'b0;
    inc_btn = 1'b0;

    // Random button traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_out);
      mode_btn = ($urandom_range(0, 7) == 0);
      inc_btn  = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk_out);
    reset = 1'b0;
    mode_btn = 1'b0;
    inc_btn = 1'b0;
    repeat (4) @(negedge clk_out);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
